// File: rtl/xpb_lut_sequencer.sv
// Time-multiplexes one shared xpb reduction table across all digit positions and sums the residues.
// Optional build macro XPB_SEQ_ZERO_SKIP_EN: zero digits are skipped instead of issued.
module xpb_lut_sequencer #(
  parameter  int DIGIT_W    = 5,
  parameter  int NUM_DIGITS = 8,
  parameter  int DATA_W     = 1024,
  parameter  int LUT_LAT    = 0,
  localparam int SEL_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int ACC_W      = DATA_W + $clog2(NUM_DIGITS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] upper_in,
  output logic                          busy,
  output logic                          done,
  output logic [ACC_W-1:0]              result,
  output logic [SEL_W-1:0]              lut_sel,
  output logic [DIGIT_W-1:0]            lut_digit,
  input  logic [DATA_W-1:0]             lut_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e                        state_q;
  logic [DIGIT_W*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]         mask_q;
  logic [SEL_W-1:0]              lut_sel_q;
  logic [DIGIT_W-1:0]            lut_digit_q;
  logic                          issue_q, last_q, busy_q, done_q;
  logic [ACC_W-1:0]              acc_q, result_q;

  // Positions still to be issued; every position unless zero digits are skipped.
  function automatic logic [NUM_DIGITS-1:0] nz_mask(input logic [DIGIT_W*NUM_DIGITS-1:0] d);
    logic [NUM_DIGITS-1:0] m;
`ifdef XPB_SEQ_ZERO_SKIP_EN
    for (int k = 0; k < NUM_DIGITS; k++) m[k] = |d[k*DIGIT_W +: DIGIT_W];
`else
    m = '1;
    if (d == '0) m = '1;
`endif
    return m;
  endfunction

  function automatic logic [SEL_W-1:0] first_set(input logic [NUM_DIGITS-1:0] m);
    logic [SEL_W-1:0] p;
    p = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) if (m[k]) p = SEL_W'(k);
    return p;
  endfunction

  logic [NUM_DIGITS-1:0]         src_mask, rest_mask;
  logic [DIGIT_W*NUM_DIGITS-1:0] src_digits;
  logic [SEL_W-1:0]              pick;
  logic [DIGIT_W-1:0]            pick_digit;
  logic [ACC_W-1:0]              acc_sum;
  logic                          acc_vld, acc_last;

  always_comb begin
    src_mask   = (state_q == IDLE) ? nz_mask(upper_in) : mask_q;
    src_digits = (state_q == IDLE) ? upper_in : digits_q;
    pick       = first_set(src_mask);
    rest_mask  = src_mask & ~(NUM_DIGITS'(1) << pick);
    pick_digit = src_digits[pick*DIGIT_W +: DIGIT_W];
    acc_sum    = acc_q + ACC_W'(lut_data);
  end

  // Issue-valid and last-issue flags delayed to line up with the table's read latency.
  generate
    if (LUT_LAT == 0) begin : g_nodly
      assign acc_vld  = issue_q;
      assign acc_last = last_q;
    end else begin : g_dly
      logic [LUT_LAT-1:0] vld_sr_q, last_sr_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_sr_q  <= '0;
          last_sr_q <= '0;
        end else begin
          vld_sr_q[0]  <= issue_q;
          last_sr_q[0] <= last_q;
          for (int i = 1; i < LUT_LAT; i++) begin
            vld_sr_q[i]  <= vld_sr_q[i-1];
            last_sr_q[i] <= last_sr_q[i-1];
          end
        end
      end
      assign acc_vld  = vld_sr_q[LUT_LAT-1];
      assign acc_last = last_sr_q[LUT_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      digits_q    <= '0;
      mask_q      <= '0;
      lut_sel_q   <= '0;
      lut_digit_q <= '0;
      issue_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      acc_q       <= '0;
      result_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            digits_q <= upper_in;
            acc_q    <= '0;
            result_q <= '0;
            if (src_mask == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q     <= ISSUE;
              busy_q      <= 1'b1;
              issue_q     <= 1'b1;
              last_q      <= (rest_mask == '0);
              lut_sel_q   <= pick;
              lut_digit_q <= pick_digit;
              mask_q      <= rest_mask;
            end
          end
        end
        ISSUE: begin
          if (mask_q != '0) begin
            issue_q     <= 1'b1;
            last_q      <= (rest_mask == '0);
            lut_sel_q   <= pick;
            lut_digit_q <= pick_digit;
            mask_q      <= rest_mask;
          end else begin
            issue_q     <= 1'b0;
            last_q      <= 1'b0;
            lut_sel_q   <= '0;
            lut_digit_q <= '0;
            if (LUT_LAT > 0) state_q <= DRAIN;
            else             state_q <= IDLE;
          end
        end
        default: ;
      endcase
      // The final accumulate closes the job from either ISSUE or DRAIN.
      if (acc_vld) begin
        acc_q <= acc_sum;
        if (acc_last) begin
          result_q <= acc_sum;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign lut_sel   = lut_sel_q;
  assign lut_digit = lut_digit_q;

endmodule

// File: tb/tb_xpb_lut_sequencer.sv
// Bench for xpb_lut_sequencer: a combinational-table and a registered-table instance share stimulus
// and are compared each cycle against a job-level reference model.
module tb_xpb_lut_sequencer;
  localparam int DIGIT_W    = 5;
  localparam int NUM_DIGITS = 8;
  localparam int DATA_W     = 1024;
  localparam int SEL_W      = 3;
  localparam int ACC_W      = DATA_W + 3;
  localparam int UW         = DIGIT_W * NUM_DIGITS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, start;
  logic [UW-1:0]     upper_in;
  logic              busy0, done0, busy1, done1;
  logic [ACC_W-1:0]  result0, result1;
  logic [SEL_W-1:0]  sel0, sel1;
  logic [DIGIT_W-1:0] dig0, dig1;
  logic [DATA_W-1:0] ld0, ld1;

  function automatic logic [DATA_W-1:0] tbl(input logic [SEL_W-1:0] s, input logic [DIGIT_W-1:0] d);
    return DATA_W'((int'(s) + 1) * int'(d));
  endfunction

  assign ld0 = tbl(sel0, dig0);
  always @(posedge clk) ld1 <= tbl(sel1, dig1);

  xpb_lut_sequencer #(.LUT_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .upper_in(upper_in),
    .busy(busy0), .done(done0), .result(result0),
    .lut_sel(sel0), .lut_digit(dig0), .lut_data(ld0));

  xpb_lut_sequencer #(.LUT_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .upper_in(upper_in),
    .busy(busy1), .done(done1), .result(result1),
    .lut_sel(sel1), .lut_digit(dig1), .lut_data(ld1));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: one job record per instance, indexed by cycle offset from acceptance.
  int               lat[2] = '{0, 1};
  bit               act[2];
  int               t0[2], dcyc[2], nis[2];
  int               isel[2][NUM_DIGITS];
  int               idg[2][NUM_DIGITS];
  logic [ACC_W-1:0] sum[2];
  bit               skip;

  function automatic bit exp_busy(input int d, input int e);
    int c;
    c = e - t0[d];
    return act[d] && c >= 1 && c < dcyc[d];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) act[d] = 1'b0;
  endtask

  task automatic model_edge(input int e);
    int dv;
    if (!rst_n) return;
    for (int d = 0; d < 2; d++) begin
      if (start && !exp_busy(d, e)) begin
        act[d] = 1'b1;
        t0[d]  = e;
        nis[d] = 0;
        sum[d] = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
          dv = int'(upper_in[k*DIGIT_W +: DIGIT_W]);
          idg[d][k] = dv;
          sum[d] = sum[d] + ACC_W'((k + 1) * dv);
          if (!skip || dv != 0) begin
            isel[d][nis[d]] = k;
            nis[d]++;
          end
        end
        dcyc[d] = (nis[d] == 0) ? 1 : nis[d] + lat[d] + 1;
      end
    end
  endtask

  task automatic check_all();
    int c, es, eg;
    bit eb, ed;
    logic [ACC_W-1:0] er;
    for (int d = 0; d < 2; d++) begin
      c  = cyc - t0[d];
      eb = exp_busy(d, cyc);
      ed = act[d] && c == dcyc[d];
      er = (act[d] && c >= dcyc[d]) ? sum[d] : '0;
      es = 0;
      eg = 0;
      if (act[d] && c >= 1 && c <= nis[d]) begin
        es = isel[d][c-1];
        eg = idg[d][es];
      end
      check_eq($sformatf("d%0d busy", d),   ACC_W'(d == 0 ? busy0 : busy1),     ACC_W'(eb));
      check_eq($sformatf("d%0d done", d),   ACC_W'(d == 0 ? done0 : done1),     ACC_W'(ed));
      check_eq($sformatf("d%0d result", d), (d == 0) ? result0 : result1,      er);
      check_eq($sformatf("d%0d lut_sel", d),   ACC_W'(d == 0 ? sel0 : sel1),    ACC_W'(es));
      check_eq($sformatf("d%0d lut_digit", d), ACC_W'(d == 0 ? dig0 : dig1),    ACC_W'(eg));
    end
  endtask

  task automatic step(input logic s, input logic [UW-1:0] u);
    start    = s;
    upper_in = u;
    @(posedge clk);
    model_edge(cyc);
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [UW-1:0] fill(input logic [DIGIT_W-1:0] v);
    logic [UW-1:0] u;
    for (int k = 0; k < NUM_DIGITS; k++) u[k*DIGIT_W +: DIGIT_W] = v;
    return u;
  endfunction

  function automatic logic [UW-1:0] rnd_upper();
    logic [UW-1:0] u;
    for (int k = 0; k < NUM_DIGITS; k++)
      u[k*DIGIT_W +: DIGIT_W] = ($urandom_range(0, 2) == 0) ? 5'd0 : DIGIT_W'($urandom_range(1, 31));
    return u;
  endfunction

  initial begin
    logic [UW-1:0] u;
`ifdef XPB_SEQ_ZERO_SKIP_EN
    skip = 1'b1;
`else
    skip = 1'b0;
`endif
    rst_n    = 1'b0;
    start    = 1'b0;
    upper_in = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    step(1'b1, fill(5'd1));
    repeat (11) step(1'b0, '0);
    step(1'b1, fill(5'd31));
    repeat (11) step(1'b0, '0);
    step(1'b1, '0);
    repeat (11) step(1'b0, '0);
    u = '0;
    u[5*DIGIT_W +: DIGIT_W] = 5'd7;
    step(1'b1, u);
    repeat (11) step(1'b0, '0);

    // Start ignored mid-job, then re-accepted in each instance's done cycle.
    step(1'b1, fill(5'd3));
    repeat (3) step(1'b0, '0);
    step(1'b1, fill(5'd9));
    repeat (4) step(1'b0, '0);
    for (int k = 0; k < NUM_DIGITS; k++) u[k*DIGIT_W +: DIGIT_W] = DIGIT_W'(k * 3);
    step(1'b1, u);
    step(1'b1, u);
    repeat (12) step(1'b0, '0);

    repeat (400) step($urandom_range(0, 3) == 0, rnd_upper());
    repeat (12) step(1'b0, '0);

    // Asynchronous reset in cycle 5 of a running job.
    step(1'b1, fill(5'd5));
    repeat (4) step(1'b0, '0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) step(1'b0, '0);
    rst_n = 1'b1;
    step(1'b1, fill(5'd4));
    repeat (12) step(1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
